// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, carry, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, carry, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, carry);
  modport slave  (input start, a, b, cin, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin using one full-adder cell, LSB first, WIDTH+1 cycles per add.
// Define SERIAL_ADDER_OVF_EN to add a signed-overflow output (bus.ovf).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, carry_q, carry_d, done_q, done_d;
  logic             fa_s, fa_c, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif
  always_comb begin
    fa_s    = a_q[0] ^ b_q[0] ^ c_q;
    fa_c    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = RUN;
        a_d     = bus.a;
        b_d     = bus.b;
        c_d     = bus.cin;
        cnt_d   = '0;
      end
    end else begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_c;
      cnt_d = cnt_q + CW'(1);
      acc_d = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      if (last) begin
        state_d = IDLE;
        sum_d   = acc_d;
        carry_d = fa_c;
        done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
        // c_q is the carry into the MSB during the final bit
        ovf_d   = c_q ^ fa_c;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign bus.busy  = state_q == RUN;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around a single full-adder cell plus a registered carry.
- Consumes the cell's sum/carry each cycle, LSB first, and assembles a WIDTH-bit result with carry-out.
- Sits downstream of the combinational full adder; trades WIDTH cycles of latency for one adder cell.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/carry are valid from this cycle on.
- sum  output  WIDTH  result of a+b+cin, modulo 2^WIDTH.
- carry  output  1  carry-out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at a rising edge):
  - busy=0, done=0, sum=0, carry=0.
  - State IDLE; all internal shift and count registers cleared.
  - Reset has priority over every other event, including mid-operation; a partial result is discarded.
- FSM states: IDLE and RUN.
- IDLE with start=1 at edge k:
  - Load a_sh=a, b_sh=b, c_reg=cin, bit count=0.
  - Go to RUN; busy=1 after edge k.
- IDLE with start=0: hold; outputs keep their last values.
- RUN, each edge k+1 .. k+WIDTH:
  - fa_s = a_sh[0]^b_sh[0]^c_reg; fa_c = majority(a_sh[0], b_sh[0], c_reg).
  - Shift fa_s into the MSB of the working sum register, shifting right.
  - a_sh and b_sh shift right with zero fill; c_reg=fa_c; count++.
- Completion, at edge k+WIDTH (last bit processed):
  - Working sum copied to sum; final fa_c copied to carry.
  - busy=0, done=1 for exactly one cycle; state returns to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH. Throughput: one addition per WIDTH+1 cycles.
- sum/carry change only at the completion edge or at reset. During RUN they hold the previous result.
- start while busy=1: ignored, no queueing.
- start=1 in the same cycle done=1: accepted (FSM is IDLE), so back-to-back operation is supported.
- a, b, cin may change freely after the accepting edge without affecting the result.
- WIDTH=1: RUN lasts one cycle; done follows edge k+1.
- Arithmetic: {carry,sum} == a + b + cin exactly, as a WIDTH+1-bit value.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Extra output port ovf (1 bit): signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf is captured from the final RUN cycle, updated and reset together with sum/carry.
- Without the macro: no ovf port and no extra registers; behaviour otherwise identical.

Test Plan:
- WIDTH=8; reset, then start with a=8'h0F, b=8'h01, cin=0 at edge k -> busy=1 during edges k+1..k+8; done pulses one cycle after edge k+8; sum=8'h10, carry=0.
- WIDTH=8; a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF, cin=1 issued in the done cycle -> accepted back-to-back; sum=8'hFF, carry=1.
- WIDTH=8; start a=8'h55, b=8'h22, then pulse start with a=8'h01, b=8'h01 at edge k+3 -> second request ignored; sum=8'h77; only one done pulse.
- WIDTH=8; start a=8'hAA, b=8'h55, assert rst at edge k+4 -> busy=0, done=0, sum=0, carry=0 after that edge; no done pulse; a following start with a=3, b=4 gives sum=7.
- WIDTH=3; exhaustive loop over all 128 {a,b,cin} combinations, each waiting for done -> {carry,sum} == a+b+cin in every case.
- SERIAL_ADDER_OVF_EN defined, WIDTH=8:
  - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1.
  - a=8'hFF, b=8'h01 -> ovf=0, carry=1.
